// File: rtl/chk_fail_report_arbiter_if.sv
// Purpose: bundles the checker-bank inputs and the report channel of chk_fail_report_arbiter.
// Latency: none (wires only).
// Backpressure: rpt_ready from the logger stalls the report channel; the checker inputs cannot be stalled.
// Ports: enable, clear, fail_pulse, rpt_ready (to arbiter);
//        rpt_valid, rpt_id, rpt_count, pending, overflow, total_fails (from arbiter).
interface chk_fail_report_arbiter_if #(
   parameter int N_CHK = 4,
   parameter int CNT_W = 16,
   parameter int ID_W  = $clog2(N_CHK)
);
   logic             enable;
   logic             clear;
   logic [N_CHK-1:0] fail_pulse;
   logic             rpt_valid;
   logic             rpt_ready;
   logic [ID_W-1:0]  rpt_id;
   logic [CNT_W-1:0] rpt_count;
   logic [N_CHK-1:0] pending;
   logic [N_CHK-1:0] overflow;
   logic [CNT_W-1:0] total_fails;

   // Checker bank and logger side.
   modport master (
      output enable, clear, fail_pulse, rpt_ready,
      input  rpt_valid, rpt_id, rpt_count, pending, overflow, total_fails
   );

   // Arbiter side.
   modport slave (
      input  enable, clear, fail_pulse, rpt_ready,
      output rpt_valid, rpt_id, rpt_count, pending, overflow, total_fails
   );
endinterface

// File: rtl/chk_fail_report_arbiter.sv
// Purpose: counts per-checker fail pulses and serialises pending failures onto one report channel, round-robin.
// Latency: fail_pulse at cycle t -> pending at t+1 -> rpt_valid at t+2 when the channel is free; one report per cycle sustained.
// Backpressure: rpt_valid & !rpt_ready holds id/count and blocks new grants; pulses keep counting and mark overflow.
// Ports: clk, rst (async, active high); bus (slave modport) carries enable, clear, fail_pulse, rpt_ready in and
//        rpt_valid, rpt_id, rpt_count, pending, overflow, total_fails out.
module chk_fail_report_arbiter #(
   parameter int N_CHK = 4,
   parameter int CNT_W = 16,
   parameter int ID_W  = $clog2(N_CHK)
) (
   input logic                     clk,
   input logic                     rst,
   chk_fail_report_arbiter_if.slave bus
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam int               SUM_W   = CNT_W + 6;   // headroom for up to 32 pulses per cycle
   localparam logic [ID_W-1:0]  LAST_RST = ID_W'(N_CHK - 1);

   logic [CNT_W-1:0] r_cnt [N_CHK];
   logic [N_CHK-1:0] r_pending;
   logic [N_CHK-1:0] r_overflow;
   logic [CNT_W-1:0] r_total;
   logic             r_valid;
   logic [ID_W-1:0]  r_id;
   logic [CNT_W-1:0] r_count;
   logic [ID_W-1:0]  r_last;

   logic [N_CHK-1:0] w_ev;
   logic [CNT_W-1:0] w_cnt_nxt [N_CHK];
   logic [SUM_W-1:0] w_sum;
   logic [CNT_W-1:0] w_total_nxt;
   logic             w_can_grant;
   logic             w_found;
   logic             w_gnt;
   logic [ID_W-1:0]  w_gnt_idx;
   logic [N_CHK-1:0] w_gnt_oh;

   assign w_ev        = bus.fail_pulse & {N_CHK{bus.enable}};
   assign w_can_grant = !r_valid || bus.rpt_ready;

   always_comb begin
      for (int i = 0; i < N_CHK; i++) begin
         w_cnt_nxt[i] = (w_ev[i] && (r_cnt[i] != CNT_MAX)) ? r_cnt[i] + 1'b1 : r_cnt[i];
      end
   end

   always_comb begin
      w_sum = {6'd0, r_total};
      for (int i = 0; i < N_CHK; i++) begin
         w_sum = w_sum + SUM_W'(w_ev[i]);
      end
      w_total_nxt = (w_sum > {6'd0, CNT_MAX}) ? CNT_MAX : w_sum[CNT_W-1:0];
   end

   // Search starts one past the last grant and wraps, so every pending checker
   // is reached within N_CHK grants.
   always_comb begin
      int v_idx;
      v_idx     = 0;
      w_found   = 1'b0;
      w_gnt_idx = '0;
      for (int k = 1; k <= N_CHK; k++) begin
         v_idx = (int'(r_last) + k) % N_CHK;
         if (!w_found && r_pending[v_idx]) begin
            w_found   = 1'b1;
            w_gnt_idx = ID_W'(v_idx);
         end
      end
      w_gnt    = w_found && w_can_grant;
      w_gnt_oh = '0;
      if (w_gnt) begin
         w_gnt_oh[w_gnt_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_CHK; i++) r_cnt[i] <= '0;
         r_pending  <= '0;
         r_overflow <= '0;
         r_total    <= '0;
         r_valid    <= 1'b0;
         r_id       <= '0;
         r_count    <= '0;
         r_last     <= LAST_RST;
      end else if (bus.clear) begin
         for (int i = 0; i < N_CHK; i++) r_cnt[i] <= '0;
         r_pending  <= '0;
         r_overflow <= '0;
         r_total    <= '0;
         r_valid    <= 1'b0;
         r_id       <= '0;
         r_count    <= '0;
         r_last     <= LAST_RST;
      end else begin
         for (int i = 0; i < N_CHK; i++) r_cnt[i] <= w_cnt_nxt[i];
         // A pulse landing on the checker being granted re-arms it instead of overflowing.
         r_pending  <= (r_pending & ~w_gnt_oh) | w_ev;
         r_overflow <= r_overflow | (w_ev & r_pending & ~w_gnt_oh);
         r_total    <= w_total_nxt;
         if (w_gnt) begin
            r_valid <= 1'b1;
            r_id    <= w_gnt_idx;
            r_count <= w_cnt_nxt[w_gnt_idx];
            r_last  <= w_gnt_idx;
         end else if (r_valid && bus.rpt_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign bus.rpt_valid   = r_valid;
   assign bus.rpt_id      = r_id;
   assign bus.rpt_count   = r_count;
   assign bus.pending     = r_pending;
   assign bus.overflow    = r_overflow;
   assign bus.total_fails = r_total;
endmodule

// File: tb/tb_chk_fail_report_arbiter.sv
// Purpose: directed self-checking bench for chk_fail_report_arbiter (N_CHK=4, CNT_W=4) with a report scoreboard.
// Latency: inputs driven 1 time unit after posedge; outputs checked there or at negedge.
// Backpressure: rpt_ready is driven per step; a negedge monitor pops expected reports on each accepted handshake.
module tb_chk_fail_report_arbiter;
   localparam int N_CHK = 4;
   localparam int CNT_W = 4;
   localparam int ID_W  = 2;

   typedef struct {
      logic [ID_W-1:0]  id;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests_run = 0;
   int   tests_failed = 0;
   exp_t q [$];

   chk_fail_report_arbiter_if #(.N_CHK(N_CHK), .CNT_W(CNT_W), .ID_W(ID_W)) bus ();

   chk_fail_report_arbiter #(.N_CHK(N_CHK), .CNT_W(CNT_W), .ID_W(ID_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input int id, input int cnt);
      exp_t e;
      e.id  = ID_W'(id);
      e.cnt = CNT_W'(cnt);
      q.push_back(e);
   endtask

   task automatic do_clear();
      bus.clear = 1'b1;
      cyc(1);
      bus.clear = 1'b0;
   endtask

   task automatic chk_rpt(input string tag, input int id, input int cnt);
      chk({tag, "_valid"}, 32'(bus.rpt_valid), 32'd1);
      chk({tag, "_id"},    32'(bus.rpt_id),    32'(id));
      chk({tag, "_count"}, 32'(bus.rpt_count), 32'(cnt));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"},    32'(bus.rpt_valid),   32'd0);
      chk({tag, "_id"},       32'(bus.rpt_id),      32'd0);
      chk({tag, "_count"},    32'(bus.rpt_count),   32'd0);
      chk({tag, "_pending"},  32'(bus.pending),     32'd0);
      chk({tag, "_overflow"}, 32'(bus.overflow),    32'd0);
      chk({tag, "_total"},    32'(bus.total_fails), 32'd0);
   endtask

   // Monitor: scoreboard pops on accepted handshakes plus the protocol properties.
   logic             p_valid = 1'b0, p_ready = 1'b0, p_clear = 1'b0;
   logic [ID_W-1:0]  p_id = '0;
   logic [CNT_W-1:0] p_count = '0;
   logic [N_CHK-1:0] p_pending = '0, p_ev = '0;

   always @(negedge clk) begin
      if (rst) begin
         p_valid = 1'b0; p_ready = 1'b0; p_clear = 1'b0;
         p_id = '0; p_count = '0; p_pending = '0; p_ev = '0;
      end else begin
         if (!p_clear) begin
            if (p_valid && !p_ready) begin
               chk("hold_valid", 32'(bus.rpt_valid), 32'd1);
               chk("hold_id",    32'(bus.rpt_id),    32'(p_id));
               chk("hold_count", 32'(bus.rpt_count), 32'(p_count));
            end
            if (bus.rpt_valid && !p_valid)
               chk("rise_needs_pending", 32'(p_pending != '0), 32'd1);
            if (bus.rpt_valid && (!p_valid || p_ready))
               chk("pending_after_grant", 32'(bus.pending[bus.rpt_id]), 32'(p_ev[bus.rpt_id]));
         end
         if (bus.rpt_valid && bus.rpt_ready && !bus.clear) begin
            if (q.size() == 0) begin
               chk("sb_unexpected_report", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("sb_id",    32'(bus.rpt_id),    32'(e.id));
               chk("sb_count", 32'(bus.rpt_count), 32'(e.cnt));
            end
         end
         p_valid   = bus.rpt_valid;
         p_ready   = bus.rpt_ready;
         p_clear   = bus.clear;
         p_id      = bus.rpt_id;
         p_count   = bus.rpt_count;
         p_pending = bus.pending;
         p_ev      = bus.fail_pulse & {N_CHK{bus.enable}};
      end
   end

   initial begin
      bus.enable     = 1'b1;
      bus.clear      = 1'b0;
      bus.fail_pulse = '0;
      bus.rpt_ready  = 1'b1;
      cyc(2);
      chk_all_zero("reset");
      rst = 1'b0;
      cyc(2);
      chk_all_zero("post_reset");

      // Single failure on checker 2.
      bus.fail_pulse = 4'b0100; push(2, 1);
      cyc(1);
      bus.fail_pulse = 4'b0000;
      chk("single_pending", 32'(bus.pending), 32'b0100);
      chk("single_novalid", 32'(bus.rpt_valid), 32'd0);
      cyc(1);
      chk_rpt("single_rpt", 2, 1);
      chk("single_pend_clr", 32'(bus.pending), 32'd0);
      cyc(1);
      chk("single_drop", 32'(bus.rpt_valid), 32'd0);
      chk("single_total", 32'(bus.total_fails), 32'd1);
      do_clear();

      // Round robin over all four.
      bus.fail_pulse = 4'b1111;
      push(0, 1); push(1, 1); push(2, 1); push(3, 1);
      cyc(1);
      bus.fail_pulse = 4'b0000;
      chk("rr_pending", 32'(bus.pending), 32'b1111);
      for (int i = 0; i < 4; i++) begin
         cyc(1);
         chk_rpt("rr_rpt", i, 1);
      end
      cyc(1);
      chk("rr_drop", 32'(bus.rpt_valid), 32'd0);
      chk("rr_total", 32'(bus.total_fails), 32'd4);
      do_clear();

      // Back-pressure and overflow on checker 1.
      bus.rpt_ready  = 1'b0;
      bus.fail_pulse = 4'b0010; push(1, 1);
      cyc(1);
      bus.fail_pulse = 4'b0000;
      cyc(1);
      chk_rpt("bp_first", 1, 1);
      for (int k = 0; k < 10; k++) begin
         bus.fail_pulse = (k == 2 || k == 5) ? 4'b0010 : 4'b0000;
         if (k == 5) push(1, 3);
         cyc(1);
         chk_rpt("bp_hold", 1, 1);
      end
      bus.fail_pulse = 4'b0000;
      chk("bp_overflow", 32'(bus.overflow), 32'b0010);
      chk("bp_pending", 32'(bus.pending), 32'b0010);
      bus.rpt_ready = 1'b1;
      cyc(1);
      chk_rpt("bp_second", 1, 3);
      cyc(1);
      chk("bp_drop", 32'(bus.rpt_valid), 32'd0);
      do_clear();
      chk("clear_overflow", 32'(bus.overflow), 32'd0);

      // Grant and pulse collide on checker 3.
      bus.fail_pulse = 4'b1000;
      cyc(1);
      push(3, 2); push(3, 2);
      cyc(1);
      bus.fail_pulse = 4'b0000;
      chk_rpt("coll_first", 3, 2);
      chk("coll_pending", 32'(bus.pending), 32'b1000);
      chk("coll_overflow", 32'(bus.overflow), 32'd0);
      cyc(1);
      chk_rpt("coll_second", 3, 2);
      cyc(1);
      chk("coll_drop", 32'(bus.rpt_valid), 32'd0);
      do_clear();

      // Enable low masks everything.
      bus.enable     = 1'b0;
      bus.fail_pulse = 4'b1111;
      cyc(3);
      bus.fail_pulse = 4'b0000;
      bus.enable     = 1'b1;
      cyc(1);
      chk_all_zero("disabled");

      // Saturation on checker 0 with the channel stalled.
      bus.rpt_ready  = 1'b0;
      push(0, 2); push(0, 15);
      bus.fail_pulse = 4'b0001;
      cyc(20);
      bus.fail_pulse = 4'b0000;
      chk("sat_total", 32'(bus.total_fails), 32'd15);
      chk_rpt("sat_first", 0, 2);
      bus.rpt_ready = 1'b1;
      cyc(1);
      chk_rpt("sat_second", 0, 15);
      cyc(1);
      chk("sat_drop", 32'(bus.rpt_valid), 32'd0);
      do_clear();

      // Clear mid-report resets the round-robin pointer.
      bus.rpt_ready  = 1'b0;
      bus.fail_pulse = 4'b1010;
      cyc(2);
      bus.fail_pulse = 4'b0000;
      chk_rpt("clr_mid_rpt", 1, 2);
      chk("clr_mid_pending", 32'(bus.pending), 32'b1010);
      bus.rpt_ready = 1'b1;
      bus.clear     = 1'b1;
      cyc(1);
      bus.clear = 1'b0;
      chk_all_zero("clr_mid");
      bus.fail_pulse = 4'b0101; push(0, 1); push(2, 1);
      cyc(1);
      bus.fail_pulse = 4'b0000;
      cyc(1);
      chk_rpt("clr_rr0", 0, 1);
      cyc(1);
      chk_rpt("clr_rr2", 2, 1);
      cyc(1);
      chk("clr_rr_drop", 32'(bus.rpt_valid), 32'd0);

      // Asynchronous reset mid-report.
      bus.rpt_ready  = 1'b0;
      bus.fail_pulse = 4'b0001;
      cyc(1);
      bus.fail_pulse = 4'b0000;
      cyc(1);
      chk("rst_pre_valid", 32'(bus.rpt_valid), 32'd1);
      #3 rst = 1'b1;
      #1 chk_all_zero("rst_async");
      cyc(1);
      rst = 1'b0;
      bus.rpt_ready = 1'b1;
      cyc(2);
      chk_all_zero("rst_after");

      chk("sb_empty", 32'(q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/chk_fail_report_arbiter.md
Name: chk_fail_report_arbiter

Overview:
- Collects fail pulses from N concurrent checker instances, static or procedural, each asserting one bit on a pass/fail event.
- Keeps per-checker fail counts, a pending flag and a sticky overflow flag for each checker.
- Serialises pending failures onto a single valid/ready report channel using round-robin arbitration.
- Sits between the checker bank and the simulation/emulation error logger.

Parameters:
- N_CHK, 4, number of checker fail inputs (2..32).
- CNT_W, 16, width of each per-checker fail counter and of the total counter.
- ID_W, $clog2(N_CHK), width of the report id.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  when low, fail_pulse is ignored; arbitration and reporting continue.
- clear  input  1  synchronous clear of all counters and flags; has priority over all other updates.
- fail_pulse  input  N_CHK  one bit per checker; high for one cycle per failure.
- rpt_valid  output  1  report available.
- rpt_ready  input  1  logger accepts the report.
- rpt_id  output  ID_W  index of the reported checker.
- rpt_count  output  CNT_W  that checker's fail count at grant time.
- pending  output  N_CHK  failure latched, not yet granted.
- overflow  output  N_CHK  sticky: a failure arrived while that checker was already pending.
- total_fails  output  CNT_W  saturating count of all failures since reset or clear.

Behaviour:
- Reset (async): all outputs 0; all counters 0; last_grant = N_CHK-1, so the first search starts at index 0.
- Event capture, per checker i, when enable=1 and fail_pulse[i]=1:
  - cnt[i] increments, saturating at 2^CNT_W-1.
  - pending[i] is set on the next edge.
  - If pending[i] is already 1 and is not being cleared by a grant this cycle, overflow[i] is set.
- total_fails adds the popcount of (fail_pulse & {N_CHK{enable}}) each cycle, saturating at 2^CNT_W-1.
- Report channel state (implicit in rpt_valid):
  - IDLE (rpt_valid=0), or REPORT with rpt_ready=1 this cycle: grant is allowed if any pending bit is 1.
  - Grant selects the first pending index in round-robin order starting at last_grant+1, wrapping modulo N_CHK.
  - On grant, next edge: rpt_valid=1, rpt_id=i, rpt_count=cnt[i] including any increment this cycle, last_grant=i, pending[i] cleared.
  - Grant and new pulse on the same i in the same cycle: pending[i] stays 1 (new event wins); overflow is not set.
  - REPORT with rpt_ready=0: rpt_valid, rpt_id and rpt_count are held stable; no grant is made.
  - Handshake (rpt_valid & rpt_ready) with no pending bits: rpt_valid goes to 0 next edge.
  - Handshake with pending bits: back-to-back grant, so rpt_valid stays 1 with new id and count.
- Latency: fail_pulse at cycle t gives pending at t+1 and rpt_valid at t+2 if the channel is free. Sustained throughput is one report per cycle.
- Fairness: a pending checker is granted within N_CHK accepted reports.
- clear=1: next edge sets cnt, pending, overflow, total_fails and rpt_valid to 0 and last_grant to N_CHK-1. Fail pulses and handshakes in the same cycle are discarded.
- rst asserted mid-report: immediate return to reset values; no report is completed.
- Saturation: counters stop at max and never wrap; rpt_count reports the saturated value.
- Required bench assertions:
  - rpt_id and rpt_count are stable while rpt_valid & !rpt_ready.
  - rpt_valid never rises without a prior pending bit.
  - pending[rpt_id] is 0 in the cycle after a grant unless a pulse arrived.

Test Plan:
- Single failure: fail_pulse=4'b0100 at cycle 5, rpt_ready=1 -> pending[2]=1 at cycle 6; rpt_valid=1, rpt_id=2, rpt_count=1 at cycle 7; rpt_valid=0 at cycle 8; total_fails=1.
- Round-robin: fail_pulse=4'b1111 for one cycle, rpt_ready=1 -> reports on 4 consecutive cycles with ids 0,1,2,3; each rpt_count=1; total_fails=4.
- Back-pressure and overflow: checker 1 fails, rpt_ready=0 for 10 cycles, then checker 1 fails twice more while pending -> id 1 and count 1 held stable 10 cycles; overflow[1]=1; after the handshake, next report is id 1 with count 3.
- Grant/pulse collision: pending[3]=1, channel free, fail_pulse[3]=1 in the grant cycle -> report id 3 with count 2; pending[3] remains 1; overflow[3]=0; a second report id 3 with count 2 follows.
- Enable and saturation: enable=0 with pulses on all bits -> no state change. With CNT_W=4 and 20 pulses on checker 0 -> cnt and rpt_count saturate at 15, total_fails=15.
- Clear and reset mid-operation:
  - clear=1 while rpt_valid=1 and pending=4'b1010 -> next cycle all outputs 0, and the next grant starts at index 0.
  - rst pulsed asynchronously mid-cycle -> outputs 0 immediately.
